// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: push side (fetch -> queue), pop side (queue -> decode),
// and the redirect flush.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. The queue raises push_ready (from its occupancy only) without
// looking at push_valid. It raises pop_valid without looking at pop_ready.
// pop_* data are meaningful only while pop_valid is 1.
interface inst_fetch_queue_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          push_valid;
  logic [AW-1:0] push_pc;
  logic [DW-1:0] push_instr;
  logic          push_ready;
  logic          pop_valid;
  logic [AW-1:0] pop_pc;
  logic [DW-1:0] pop_instr;
  logic          pop_misal;
  logic          pop_ready;
  logic          flush;

  // Fetch/decode side: drives entries in, consumes entries out.
  modport master (
    output push_valid, push_pc, push_instr, pop_ready, flush,
    input  push_ready, pop_valid, pop_pc, pop_instr, pop_misal
  );

  // Queue side.
  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready, flush,
    output push_ready, pop_valid, pop_pc, pop_instr, pop_misal
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers {PC, instruction} pairs between fetch and
// decode. Decode stalls therefore do not freeze the PC until the queue fills.
// A redirect (flush) drops everything buffered.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,    // asynchronous, active-low
  inst_fetch_queue_if.slave      bus,
  output logic [CW-1:0]          count
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] pc_mem_q    [DEPTH];
  logic [DW-1:0] instr_mem_q [DEPTH];
  logic          misal_mem_q [DEPTH];

  logic push_fire;
  logic pop_fire;

  // Status flags depend on occupancy alone. There is no bypass path, so a
  // pop that frees a full queue lets a push in only on the following cycle.
  assign bus.push_ready = (count_q != CW'(DEPTH));
  assign bus.pop_valid  = (count_q != '0);

  assign push_fire = bus.push_valid & bus.push_ready;
  assign pop_fire  = bus.pop_valid  & bus.pop_ready;

  // The head entry is always presented. pop_valid qualifies it, which also
  // hides stale storage after a flush.
  assign bus.pop_pc    = pc_mem_q[rd_ptr_q];
  assign bus.pop_instr = instr_mem_q[rd_ptr_q];
  assign bus.pop_misal = misal_mem_q[rd_ptr_q];
  assign count         = count_q;

  // Next pointer/occupancy. Flush overrides both push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. The misaligned flag is captured with the entry at push
  // time and is not recomputed at the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
        misal_mem_q[i] <= 1'b0;
      end
    end else if (push_fire && !bus.flush) begin
      pc_mem_q[wr_ptr_q]    <= bus.push_pc;
      instr_mem_q[wr_ptr_q] <= bus.push_instr;
      misal_mem_q[wr_ptr_q] <= (bus.push_pc[1:0] != 2'b00);
    end
  end
endmodule
